// File: rtl/tsmac_rx_fifo_unpacker.sv
// tsmac_rx_fifo_unpacker: pops RX FIFO words into a byte stream with frame-length truncation and frame counters
module tsmac_rx_fifo_unpacker #(
    parameter int MAX_LEN = 1518,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             fifo_rd_en,
    input  logic [9:0]       fifo_rd_data,
    input  logic             fifo_rd_empty,
    output logic [7:0]       m_tdata,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic             m_tlast,
    output logic             m_tuser,
    output logic [CNT_W-1:0] frm_cnt,
    output logic [CNT_W-1:0] err_cnt
);
    localparam int BW = $clog2(MAX_LEN + 1);
    localparam logic [BW-1:0] LAST_IDX = BW'(MAX_LEN - 1);
    typedef enum logic [1:0] {IDLE, BODY, DROP} state_t;
    state_t state, state_nx;
    logic [BW-1:0] byte_cnt, cnt_nx;
    logic rd_pend, push, pop, push_last, push_user, wr_ptr, rd_ptr, eof;
    logic [1:0] occ;
    logic [9:0] buf_q [2];
    logic [9:0] head;
    assign eof = fifo_rd_data[8];
    assign pop = m_tvalid & m_tready;
    // Words already in flight (rd_pend) reserve a slot, so the 2-entry buffer can never overrun.
    assign fifo_rd_en = rst_n && !fifo_rd_empty && (({1'b0, occ} + {2'b0, rd_pend}) < (3'd2 + {2'b0, pop}));
    assign head = buf_q[rd_ptr];
    assign m_tdata = head[9:2];
    assign m_tlast = head[1];
    assign m_tuser = head[0];
    assign m_tvalid = occ != 2'd0;
    always_comb begin
        state_nx = state;
        cnt_nx = byte_cnt;
        push = 1'b0;
        push_last = 1'b0;
        push_user = 1'b0;
        if (rd_pend) begin
            if (state == DROP) begin
                state_nx = eof ? IDLE : DROP;
                cnt_nx = '0;
            end else if (eof) begin
                push = 1'b1;
                push_last = 1'b1;
                push_user = fifo_rd_data[9];
                cnt_nx = '0;
                state_nx = IDLE;
            end else if (byte_cnt != LAST_IDX) begin
                push = 1'b1;
                cnt_nx = byte_cnt + BW'(1);
                state_nx = BODY;
            end else begin
                push = 1'b1;
                push_last = 1'b1;
                push_user = 1'b1;
                cnt_nx = '0;
                state_nx = DROP;
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            byte_cnt <= '0;
            rd_pend <= 1'b0;
        end else begin
            state <= state_nx;
            byte_cnt <= cnt_nx;
            rd_pend <= fifo_rd_en;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q[0] <= '0;
            buf_q[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ <= 2'd0;
        end else begin
            if (push) begin
                buf_q[wr_ptr] <= {fifo_rd_data[7:0], push_last, push_user};
                wr_ptr <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            occ <= occ + {1'b0, push} - {1'b0, pop};
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frm_cnt <= '0;
            err_cnt <= '0;
        end else if (pop && m_tlast) begin
            if (!m_tuser && !(&frm_cnt)) frm_cnt <= frm_cnt + 1'b1;
            if (m_tuser && !(&err_cnt)) err_cnt <= err_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_tsmac_rx_fifo_unpacker.sv
// tb_tsmac_rx_fifo_unpacker: directed bench, instance 0 default parameters, instance 1 MAX_LEN=8 CNT_W=4
module tb_tsmac_rx_fifo_unpacker;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rdy = 1'b0;
    logic rd_en0, rd_en1, tvalid0, tvalid1, tlast0, tlast1, tuser0, tuser1;
    logic empty0 = 1'b1;
    logic empty1 = 1'b1;
    logic [9:0] rd_data0 = '0;
    logic [9:0] rd_data1 = '0;
    logic [7:0] tdata0, tdata1;
    logic [15:0] frm0, err0;
    logic [3:0] frm1, err1;
    logic [9:0] q0[$], q1[$], cap0[$], cap1[$], held;
    int ct0[$];
    int cyc = 0, checks = 0, errors = 0, rd_viol = 0, stall_viol = 0, first_cyc = 0, last_cyc = 0;
    logic held_v = 1'b0;

    always #5 clk = ~clk;

    tsmac_rx_fifo_unpacker u_dut0 (
        .clk(clk), .rst_n(rst_n), .fifo_rd_en(rd_en0), .fifo_rd_data(rd_data0), .fifo_rd_empty(empty0),
        .m_tdata(tdata0), .m_tvalid(tvalid0), .m_tready(rdy), .m_tlast(tlast0), .m_tuser(tuser0),
        .frm_cnt(frm0), .err_cnt(err0));

    tsmac_rx_fifo_unpacker #(.MAX_LEN(8), .CNT_W(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .fifo_rd_en(rd_en1), .fifo_rd_data(rd_data1), .fifo_rd_empty(empty1),
        .m_tdata(tdata1), .m_tvalid(tvalid1), .m_tready(rdy), .m_tlast(tlast1), .m_tuser(tuser1),
        .frm_cnt(frm1), .err_cnt(err1));

    // FIFO models: read latency 1, empty flag follows the queue one edge later
    always @(posedge clk) begin
        cyc++;
        if (rd_en0) begin
            if (empty0 || q0.size() == 0) rd_viol++;
            else rd_data0 <= q0.pop_front();
        end
        if (rd_en1) begin
            if (empty1 || q1.size() == 0) rd_viol++;
            else rd_data1 <= q1.pop_front();
        end
        empty0 <= (q0.size() == 0);
        empty1 <= (q1.size() == 0);
    end

    always @(negedge clk) begin
        if (held_v && tvalid0 && {tdata0, tlast0, tuser0} != held) stall_viol++;
        held_v = tvalid0 && !rdy && rst_n;
        held = {tdata0, tlast0, tuser0};
        if (tvalid0 && rdy) begin
            cap0.push_back({tdata0, tlast0, tuser0});
            ct0.push_back(cyc);
        end
        if (tvalid1 && rdy) cap1.push_back({tdata1, tlast1, tuser1});
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push_frame(input int sel, input int n, input int base, input int err_idx);
        logic [9:0] w;
        for (int i = 0; i < n; i++) begin
            w = {i == err_idx, i == n - 1, 8'(base + i)};
            if (sel == 0) q0.push_back(w);
            else q1.push_back(w);
        end
    endtask

    task automatic check_frame(input int sel, input int n, input int base, input int user);
        logic [9:0] w, e;
        int c;
        for (int i = 0; i < n; i++) begin
            chk($sformatf("beat_avail%0d_%0d", sel, i), ((sel == 0 ? cap0.size() : cap1.size()) > 0) ? 1 : 0, 1);
            w = '0;
            if (sel == 0 && cap0.size() > 0) begin
                w = cap0.pop_front();
                c = ct0.pop_front();
                if (i == 0) first_cyc = c;
                last_cyc = c;
            end else if (sel == 1 && cap1.size() > 0) begin
                w = cap1.pop_front();
            end
            e = {8'(base + i), i == n - 1, (i == n - 1) ? user[0] : 1'b0};
            chk($sformatf("beat%0d_%0d", sel, i), int'(w), int'(e));
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        cycles(3);
        chk("rst_valid", tvalid0, 0);
        chk("rst_data", tdata0, 0);
        chk("rst_last", tlast0, 0);
        chk("rst_user", tuser0, 0);
        chk("rst_rden", rd_en0, 0);
        chk("rst_frm", frm0, 0);
        chk("rst_err", err0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cycles(2);
        // 10-byte frame, ready held high: back-to-back beats
        rdy = 1'b1;
        push_frame(0, 10, 8'h01, -1);
        cycles(30);
        check_frame(0, 10, 8'h01, 0);
        chk("tput_span", last_cyc - first_cyc, 9);
        chk("extra0_a", cap0.size(), 0);
        chk("frm0_a", frm0, 1);
        chk("err0_a", err0, 0);
        // same frame with ready toggling
        push_frame(0, 10, 8'h01, -1);
        for (int i = 0; i < 40; i++) begin
            cycles(1);
            rdy = ~rdy;
        end
        rdy = 1'b1;
        cycles(20);
        check_frame(0, 10, 8'h01, 0);
        chk("extra0_b", cap0.size(), 0);
        chk("frm0_b", frm0, 2);
        chk("stall_stable", stall_viol, 0);
        // MAX_LEN=8: 12-byte frame truncated, then a 3-byte frame intact
        push_frame(1, 12, 8'h10, -1);
        push_frame(1, 3, 8'h30, -1);
        cycles(40);
        check_frame(1, 8, 8'h10, 1);
        check_frame(1, 3, 8'h30, 0);
        chk("extra1_a", cap1.size(), 0);
        chk("err1_a", err1, 1);
        chk("frm1_a", frm1, 1);
        // exactly MAX_LEN with mac_err on a non-eof word, then mac_err on eof
        push_frame(1, 8, 8'h60, 2);
        push_frame(1, 3, 8'h70, 2);
        cycles(40);
        check_frame(1, 8, 8'h60, 0);
        check_frame(1, 3, 8'h70, 1);
        chk("extra1_b", cap1.size(), 0);
        chk("frm1_b", frm1, 2);
        chk("err1_b", err1, 2);
        // stall with buffer full, then async reset mid-frame
        rdy = 1'b0;
        push_frame(1, 6, 8'h40, -1);
        cycles(8);
        chk("full_valid", tvalid1, 1);
        chk("full_head", tdata1, 8'h40);
        chk("full_rden", rd_en1, 0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", tvalid1, 0);
        chk("arst_data", tdata1, 0);
        chk("arst_last", tlast1, 0);
        chk("arst_user", tuser1, 0);
        chk("arst_rden", rd_en1, 0);
        chk("arst_frm", frm1, 0);
        chk("arst_err", err1, 0);
        q1.delete();
        cycles(2);
        @(negedge clk);
        rst_n = 1'b1;
        rdy = 1'b1;
        push_frame(1, 4, 8'h50, -1);
        cycles(20);
        check_frame(1, 4, 8'h50, 0);
        chk("extra1_c", cap1.size(), 0);
        chk("frm1_c", frm1, 1);
        // counter saturation at 15 with CNT_W=4
        for (int i = 0; i < 14; i++) push_frame(1, 1, 8'h80 + i, -1);
        cycles(40);
        for (int i = 0; i < 14; i++) check_frame(1, 1, 8'h80 + i, 0);
        chk("frm1_15", frm1, 15);
        for (int i = 0; i < 3; i++) push_frame(1, 1, 8'hA0 + i, -1);
        cycles(20);
        for (int i = 0; i < 3; i++) check_frame(1, 1, 8'hA0 + i, 0);
        chk("frm1_sat", frm1, 15);
        chk("err1_sat", err1, 0);
        chk("extra1_d", cap1.size(), 0);
        chk("rd_when_empty", rd_viol, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/tsmac_rx_fifo_unpacker.md
Name: tsmac_rx_fifo_unpacker

Overview:
- Sits directly downstream of the TSMAC RX clock-crossing FIFO (10-bit words, depth 32, read latency 1 with no output register), in the read-clock domain.
- Pops words from the FIFO and splits each into a byte plus frame flags.
- Enforces a maximum frame length by truncating and dropping oversized frames.
- Presents frames on a valid/ready byte stream with last/error sideband; keeps saturating good- and error-frame counters.

Parameters:
- MAX_LEN, 1518, maximum bytes per frame delivered; longer frames are truncated and flagged.
- CNT_W, 16, width of the frame statistics counters.

Ports:
- clk  input  1  single clock (FIFO read clock)
- rst_n  input  1  asynchronous active-low reset
- fifo_rd_en  output  1  FIFO read strobe
- fifo_rd_data  input  10  FIFO word: [7:0] byte, [8] eof, [9] mac_err
- fifo_rd_empty  input  1  FIFO empty flag
- m_tdata  output  8  output byte
- m_tvalid  output  1  output byte valid
- m_tready  input  1  downstream accept
- m_tlast  output  1  last byte of frame
- m_tuser  output  1  frame error (mac_err or truncation); meaningful when m_tlast=1
- frm_cnt  output  CNT_W  frames delivered with m_tuser=0, saturating
- err_cnt  output  CNT_W  frames delivered with m_tuser=1, saturating

Behaviour:
- Reset (rst_n=0, async):
  - fifo_rd_en=0, m_tvalid=0, m_tdata=0, m_tlast=0, m_tuser=0, frm_cnt=0, err_cnt=0.
  - Buffer emptied, state IDLE, byte counter 0, rd_pend=0.
  - FIFO contents are not flushed by this block.
- Read issue:
  - fifo_rd_data is valid the cycle after fifo_rd_en=1; rd_pend registers fifo_rd_en.
  - pop = m_tvalid & m_tready.
  - fifo_rd_en = !fifo_rd_empty && (occ + rd_pend - pop) < 2, where occ is the registered occupancy of the 2-entry output buffer.
  - Never read when empty; no FIFO overrun of the buffer.
  - Sustains 1 byte/clk when m_tready is held 1.
- Output buffer:
  - 2-entry FIFO of {tdata, tlast, tuser}; head drives m_*.
  - m_* held stable while m_tvalid=1 and m_tready=0.
  - Push and pop in the same cycle are allowed; occ is unchanged.
- Write-side FSM, evaluated on each returned word (rd_pend=1); byte_cnt counts bytes pushed in the current frame:
  - IDLE/BODY, eof=1: push with tlast=1, tuser=mac_err; byte_cnt=0; go to IDLE.
  - IDLE/BODY, eof=0, byte_cnt+1 < MAX_LEN: push with tlast=0; byte_cnt++; go to BODY.
  - IDLE/BODY, eof=0, byte_cnt+1 == MAX_LEN: push with tlast=1, tuser=1 (truncation); go to DROP.
  - DROP: discard the word (no push). On eof=1 go to IDLE with byte_cnt=0, else stay in DROP.
  - A frame of exactly MAX_LEN bytes ending in eof is legal (tuser=mac_err).
  - A single-word frame (eof on the first byte) is legal.
  - mac_err on a non-eof word is ignored; only the eof word's bit 9 counts.
- Counters:
  - Update on pop with m_tlast=1: tuser=0 increments frm_cnt, tuser=1 increments err_cnt.
  - Both hold at all-ones.
  - Dropped words do not touch the counters.
- Reset mid-frame: the FSM returns to IDLE. The FIFO's remaining words of that frame are then treated as a new frame, which is acceptable because the FIFO is reset on the same event.

Test Plan:
- Frame of 10 bytes 0x01..0x0A, eof on 0x0A, m_tready=1 -> ten beats, one per clk after startup; m_tlast only on 0x0A; m_tuser=0; frm_cnt=1; fifo_rd_en never asserted while fifo_rd_empty=1.
- Same frame with m_tready toggling 1,0,1,0 -> bytes delivered in order with no loss or duplication; m_* stable during stalls; occ never exceeds 2.
- MAX_LEN=8, frame of 12 bytes -> 8 beats delivered; 8th beat has m_tlast=1, m_tuser=1; 4 bytes dropped; err_cnt=1. A following 3-byte frame is delivered intact with frm_cnt=1.
- Exactly-8-byte frame with MAX_LEN=8 -> 8 beats, last with m_tuser=0, frm_cnt increments. Frame with mac_err=1 on eof -> m_tuser=1, err_cnt increments.
- rst_n pulled low mid-frame with 2 bytes buffered -> all outputs 0 immediately (async), counters 0; after release and a FIFO reset, a new 4-byte frame is delivered correctly.
- CNT_W=4, 17 good frames -> frm_cnt saturates at 15.
